// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: channel state
// encoding, minimum legal divisor and the divisor clamp used on writes.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int unsigned DIV_MIN = 2;

    // Divisors below DIV_MIN cannot form a two-phase period, so lift them.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < DIV_MIN) ? 32'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the divider: per-channel run request and divisor
// write path in, divided clocks and status pulses out.
interface clk_div_prog_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
);

    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       div_wr;
    logic [NUM_CH*DIV_W-1:0] div_in;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       upd_done;

    modport master (
        output en, div_wr, div_in,
        input  clk_out, tick, busy, upd_done
    );

    modport slave (
        input  en, div_wr, div_in,
        output clk_out, tick, busy, upd_done
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter with IDLE/RUN control, shadowed divisor
// that only takes effect at period boundaries, and a negedge half-cycle stretch.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 12
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             upd_done
);

    chan_state_t      state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half;
    logic             pending;
    logic             clk_p;
    logic             clk_n;

    assign cnt_inc = cnt + DIV_W'(1);
    assign half    = active >> 1;
    assign busy    = (state == RUN);

    // Odd divisors keep the output high for an extra half cycle via clk_n.
    assign clk_out = clk_p | (active[0] & busy & clk_n);

    // Divisor write is placed after the FSM so a write landing on a boundary
    // leaves pending set for the following boundary.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            clk_p    <= 1'b0;
            tick     <= 1'b0;
            upd_done <= 1'b0;
            shadow   <= DIV_W'(DIV_INIT);
            active   <= DIV_W'(DIV_INIT);
            pending  <= 1'b0;
        end else begin
            tick     <= 1'b0;
            upd_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    clk_p <= 1'b0;
                    if (en) begin
                        state    <= RUN;
                        active   <= shadow;
                        clk_p    <= 1'b1;
                        tick     <= 1'b1;
                        upd_done <= pending;
                        pending  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt != active - DIV_W'(1)) begin
                        cnt   <= cnt_inc;
                        clk_p <= (cnt_inc < half);
                    end else if (en) begin
                        cnt      <= '0;
                        clk_p    <= 1'b1;
                        tick     <= 1'b1;
                        active   <= shadow;
                        upd_done <= pending;
                        pending  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        clk_p <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (div_wr) begin
                shadow  <= DIV_W'(clamp_div(32'(div_in)));
                pending <= 1'b1;
            end
        end
    end

    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            clk_n <= 1'b0;
        end else begin
            clk_n <= clk_p;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: NUM_CH independent channels all
// dividing clk_in, each with its own divisor slice of div_in.
module clk_div_prog #(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 12
) (
    input  logic          clk_in,
    input  logic          rst,
    clk_div_prog_if.slave bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_chan (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (bus.en[i]),
            .div_wr   (bus.div_wr[i]),
            .div_in   (bus.div_in[i*DIV_W +: DIV_W]),
            .clk_out  (bus.clk_out[i]),
            .tick     (bus.tick[i]),
            .busy     (bus.busy[i]),
            .upd_done (bus.upd_done[i])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random traffic,
// compared half-cycle by half-cycle against a period-level reference model.
module tb_clk_div_prog;

    localparam int NUM_CH   = 2;
    localparam int DIV_W    = 8;
    localparam int DIV_INIT = 12;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    int errors = 0;
    int checks = 0;

    clk_div_prog_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    clk_div_prog #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: a channel runs back-to-back periods of m_len cycles;
    // m_pos is the cycle index inside the current period. A new period starts
    // whenever the previous one is over (or none is running) and en is high.
    bit m_run     [NUM_CH];
    int m_pos     [NUM_CH];
    int m_len     [NUM_CH];
    int m_shadow  [NUM_CH];
    bit m_pending [NUM_CH];
    bit m_tick    [NUM_CH];
    bit m_upd     [NUM_CH];

    always @(posedge clk_in or posedge rst) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rst) begin
                m_run[ch]     = 1'b0;
                m_pos[ch]     = 0;
                m_len[ch]     = DIV_INIT;
                m_shadow[ch]  = DIV_INIT;
                m_pending[ch] = 1'b0;
                m_tick[ch]    = 1'b0;
                m_upd[ch]     = 1'b0;
            end else begin
                int d;
                m_tick[ch] = 1'b0;
                m_upd[ch]  = 1'b0;
                if (m_run[ch] && m_pos[ch] < m_len[ch] - 1) begin
                    m_pos[ch] = m_pos[ch] + 1;
                end else if (bus.en[ch]) begin
                    m_run[ch]     = 1'b1;
                    m_pos[ch]     = 0;
                    m_len[ch]     = m_shadow[ch];
                    m_tick[ch]    = 1'b1;
                    m_upd[ch]     = m_pending[ch];
                    m_pending[ch] = 1'b0;
                end else begin
                    m_run[ch] = 1'b0;
                    m_pos[ch] = 0;
                end
                if (bus.div_wr[ch]) begin
                    d             = int'(bus.div_in[ch*DIV_W +: DIV_W]);
                    m_shadow[ch]  = (d < 2) ? 2 : d;
                    m_pending[ch] = 1'b1;
                end
            end
        end
    end

    // A period of D cycles is 2*D half-cycles; the first D of them are high.
    function automatic logic [NUM_CH-1:0] exp_clk(input int half_idx);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            r[ch] = m_run[ch] && (2 * m_pos[ch] + half_idx < m_len[ch]);
        return r;
    endfunction

    function automatic logic [4*NUM_CH-1:0] exp_first();
        logic [NUM_CH-1:0] t, b, u;
        t = '0; b = '0; u = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            t[ch] = m_tick[ch];
            b[ch] = m_run[ch];
            u[ch] = m_upd[ch];
        end
        return {exp_clk(0), t, b, u};
    endfunction

    function automatic logic [4*NUM_CH-1:0] outs();
        return {bus.clk_out, bus.tick, bus.busy, bus.upd_done};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got=%b want=%b", outs(), {4*NUM_CH{1'b0}});
        end
        @(negedge clk_in); #1;
        rst = 1'b0;
        checks++;
        if (bus.clk_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release got=%b want=00", bus.clk_out);
        end
    endtask

    task automatic test_default();
        int ticks = 0, highs = 0;
        bus.en = 2'b01;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL default_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            if (c == 0) begin
                checks++;
                if (bus.clk_out[0] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL default_latency got=%b want=1", bus.clk_out[0]);
                end
            end
            ticks += int'(bus.tick[0]);
            highs += int'(bus.clk_out[0]);
            @(negedge clk_in); #1;
            checks++;
            if (bus.clk_out !== exp_clk(1)) begin
                errors++;
                $display("[TB] FAIL default_mid t=%0t got=%b want=%b", $time, bus.clk_out, exp_clk(1));
            end
            highs += int'(bus.clk_out[0]);
        end
        checks++;
        if (ticks !== 2) begin
            errors++;
            $display("[TB] FAIL default_ticks got=%0d want=2", ticks);
        end
        checks++;
        if (highs !== 24) begin
            errors++;
            $display("[TB] FAIL default_high_halves got=%0d want=24", highs);
        end
    endtask

    task automatic test_div_change();
        int ticks = 0, upds = 0, highs = 0;
        for (int c = 0; c < 30; c++) begin
            bus.div_wr = (c == 3) ? 2'b01 : 2'b00;
            bus.div_in = {8'd0, 8'd5};
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL divchg_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            ticks += int'(bus.tick[0]);
            upds  += int'(bus.upd_done[0]);
            if (c >= 12 && c <= 26) highs += int'(bus.clk_out[0]);
            @(negedge clk_in); #1;
            checks++;
            if (bus.clk_out !== exp_clk(1)) begin
                errors++;
                $display("[TB] FAIL divchg_mid t=%0t got=%b want=%b", $time, bus.clk_out, exp_clk(1));
            end
            if (c >= 12 && c <= 26) highs += int'(bus.clk_out[0]);
        end
        bus.div_wr = '0;
        checks++;
        if (ticks !== 5 || upds !== 1) begin
            errors++;
            $display("[TB] FAIL divchg_pulses ticks=%0d upd=%0d want ticks=5 upd=1", ticks, upds);
        end
        checks++;
        if (highs !== 15) begin
            errors++;
            $display("[TB] FAIL divchg_high_halves got=%0d want=15", highs);
        end
    endtask

    task automatic test_clamp();
        for (int c = 0; c < 12; c++) begin
            bus.div_wr = (c == 0) ? 2'b10 : 2'b00;
            bus.div_in = '0;
            if (c == 1) bus.en = 2'b11;
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL clamp_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            if (c >= 1) begin
                checks++;
                if (bus.clk_out[1] !== 1'((c - 1) % 2 == 0)) begin
                    errors++;
                    $display("[TB] FAIL clamp_toggle c=%0d got=%b want=%b", c, bus.clk_out[1], 1'((c - 1) % 2 == 0));
                end
            end
            @(negedge clk_in); #1;
            checks++;
            if (bus.clk_out !== exp_clk(1)) begin
                errors++;
                $display("[TB] FAIL clamp_mid t=%0t got=%b want=%b", $time, bus.clk_out, exp_clk(1));
            end
        end
    endtask

    task automatic test_drop_en();
        int n = 0, highs = 0;
        bus.div_wr = 2'b01;
        bus.div_in = {8'd0, 8'd8};
        while (!(m_run[0] && m_len[0] == 8 && m_pos[0] == 3) && n < 60) begin
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL drop_wait_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            @(negedge clk_in); #1;
            checks++;
            if (bus.clk_out !== exp_clk(1)) begin
                errors++;
                $display("[TB] FAIL drop_wait_mid t=%0t got=%b want=%b", $time, bus.clk_out, exp_clk(1));
            end
            bus.div_wr = '0;
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("[TB] FAIL drop_reach_cnt3 cycles=%0d limit=60", n);
        end
        bus.en[0] = 1'b0;
        n = 0;
        while (bus.busy[0] !== 1'b0 && n < 20) begin
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL drop_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            highs += int'(bus.clk_out[0]);
            @(negedge clk_in); #1;
            checks++;
            if (bus.clk_out !== exp_clk(1)) begin
                errors++;
                $display("[TB] FAIL drop_mid t=%0t got=%b want=%b", $time, bus.clk_out, exp_clk(1));
            end
            highs += int'(bus.clk_out[0]);
            n++;
        end
        checks++;
        if (n !== 5 || highs !== 0) begin
            errors++;
            $display("[TB] FAIL drop_to_idle cycles=%0d highs=%0d want cycles=5 highs=0", n, highs);
        end
    endtask

    task automatic test_boundary_write();
        int n = 0;
        bus.div_wr = 2'b10;
        bus.div_in = {8'd4, 8'd0};
        while (!(m_run[1] && m_len[1] == 4 && m_pos[1] == 3) && n < 40) begin
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL bndwr_wait_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            @(negedge clk_in); #1;
            bus.div_wr = '0;
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("[TB] FAIL bndwr_reach_boundary cycles=%0d limit=40", n);
        end
        bus.div_wr = 2'b10;
        bus.div_in = {8'd7, 8'd0};
        for (int c = 0; c < 13; c++) begin
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL bndwr_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            checks++;
            if (bus.tick[1] !== 1'(c == 0 || c == 4 || c == 11) || bus.upd_done[1] !== 1'(c == 4)) begin
                errors++;
                $display("[TB] FAIL bndwr_pulses c=%0d tick=%b upd=%b want tick=%b upd=%b",
                         c, bus.tick[1], bus.upd_done[1], 1'(c == 0 || c == 4 || c == 11), 1'(c == 4));
            end
            @(negedge clk_in); #1;
            checks++;
            if (bus.clk_out !== exp_clk(1)) begin
                errors++;
                $display("[TB] FAIL bndwr_mid t=%0t got=%b want=%b", $time, bus.clk_out, exp_clk(1));
            end
            bus.div_wr = '0;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, highs = 0;
        int ticks [NUM_CH];
        ticks = '{0, 0};
        bus.en     = 2'b11;
        bus.div_wr = 2'b11;
        bus.div_in = {8'd3, 8'd9};
        while (!(m_len[0] == 9 && m_len[1] == 3 && m_pos[0] == 4) && n < 60) begin
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL rstmid_wait_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            @(negedge clk_in); #1;
            bus.div_wr = '0;
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("[TB] FAIL rstmid_reach_mid cycles=%0d limit=60", n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_async got=%b want=%b", outs(), {4*NUM_CH{1'b0}});
        end
        @(posedge clk_in); #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_held got=%b want=%b", outs(), {4*NUM_CH{1'b0}});
        end
        @(negedge clk_in); #1;
        rst = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL rstmid_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            if (c == 0) begin
                checks++;
                if (bus.clk_out !== 2'b11) begin
                    errors++;
                    $display("[TB] FAIL rstmid_restart got=%b want=11", bus.clk_out);
                end
            end
            for (int ch = 0; ch < NUM_CH; ch++) ticks[ch] += int'(bus.tick[ch]);
            highs += int'(bus.clk_out[0]);
            @(negedge clk_in); #1;
            checks++;
            if (bus.clk_out !== exp_clk(1)) begin
                errors++;
                $display("[TB] FAIL rstmid_mid t=%0t got=%b want=%b", $time, bus.clk_out, exp_clk(1));
            end
            highs += int'(bus.clk_out[0]);
        end
        checks++;
        if (ticks[0] !== 2 || ticks[1] !== 2 || highs !== 24) begin
            errors++;
            $display("[TB] FAIL rstmid_div12 ticks0=%0d ticks1=%0d highs0=%0d want 2 2 24", ticks[0], ticks[1], highs);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.div_wr = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 15) == 0) bus.en[ch] = ~bus.en[ch];
                if ($urandom_range(0, 9) == 0) begin
                    bus.div_wr[ch] = 1'b1;
                    bus.div_in[ch*DIV_W +: DIV_W] = DIV_W'(($urandom_range(0, 7) == 0) ?
                                                    $urandom_range(0, 40) : $urandom_range(0, 9));
                end
            end
            @(posedge clk_in); #1;
            checks++;
            if (outs() !== exp_first()) begin
                errors++;
                $display("[TB] FAIL random_edge t=%0t got=%b want=%b", $time, outs(), exp_first());
            end
            @(negedge clk_in); #1;
            checks++;
            if (bus.clk_out !== exp_clk(1)) begin
                errors++;
                $display("[TB] FAIL random_mid t=%0t got=%b want=%b", $time, bus.clk_out, exp_clk(1));
            end
        end
        bus.div_wr = '0;
    endtask

    initial begin
        bus.en     = '0;
        bus.div_wr = '0;
        bus.div_in = '0;
        $display("[TB] clk_div_prog bench start");
        test_reset();
        test_default();
        test_div_change();
        test_clamp();
        test_drop_en();
        test_boundary_write();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel, run-time programmable clock divider for the 8051 core.
- Each channel produces a 50%-duty divided clock for any divisor, even or odd, plus a single-cycle tick enable.
- Typical consumers: machine-cycle timing (÷12), timers, UART baud.
- Divisor changes and enable/disable take effect only at period boundaries, so outputs never glitch.

Parameters:
- NUM_CH, 2, number of independent divider channels.
- DIV_W, 8, divisor width in bits; legal divisors are 2..2^DIV_W-1.
- DIV_INIT, 12, divisor loaded into every channel's shadow register at reset.

Ports:
- clk_in  input  1  single clock for the block; every channel divides this clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  NUM_CH  per-channel run request.
- div_wr  input  NUM_CH  per-channel divisor write strobe, one cycle.
- div_in  input  NUM_CH*DIV_W  per-channel divisor value; channel i uses bits [i*DIV_W +: DIV_W].
- clk_out  output  NUM_CH  divided clock, 50% duty.
- tick  output  NUM_CH  one-clk_in-cycle pulse at the start of each output period.
- busy  output  NUM_CH  channel is in RUN.
- upd_done  output  NUM_CH  one-cycle pulse when a pending divisor becomes active.

Behaviour:
- Reset (async, rst=1), all channels:
  - state=IDLE, cnt=0, clk_p=0, clk_n=0.
  - clk_out=0, tick=0, busy=0, upd_done=0.
  - shadow=DIV_INIT, active=DIV_INIT, pending=0.
  - Asserting rst mid-period forces all of the above immediately. There is no completion of the current period.
- Divisor write:
  - When div_wr[i]=1, shadow <= div_in slice and pending <= 1.
  - Values 0 and 1 are clamped to 2.
  - Writes in consecutive cycles: the last one wins.
- State machine per channel, evaluated on posedge clk_in:
  - IDLE, en=1: go to RUN. active <= shadow; cnt <= 0; clk_p <= 1; tick <= 1; upd_done <= pending; pending <= 0.
  - IDLE, en=0: stay; all outputs 0.
  - RUN, cnt != active-1: cnt <= cnt+1; clk_p <= (cnt+1 < H), where H = floor(active/2).
  - RUN, cnt == active-1 (period boundary), en=1: cnt <= 0; clk_p <= 1; tick <= 1; active <= shadow; upd_done <= pending; pending <= 0.
  - RUN, cnt == active-1 (period boundary), en=0: go to IDLE; clk_p <= 0; cnt <= 0.
  - Dropping en mid-period always completes the current period.
- Negative-edge half-cycle extension:
  - On negedge clk_in, clk_n <= clk_p.
  - clk_out = clk_p | (active odd & busy ? clk_n : 0).
  - Result: high time is H cycles for even divisors and H+0.5 cycles for odd divisors, so duty is exactly 50%.
- Simultaneous div_wr and boundary in the same cycle:
  - The boundary loads the old shadow.
  - The new value lands in shadow with pending=1 and applies at the next boundary.
- Other fixed outputs and timing:
  - tick is a registered pulse coincident with the rising edge of clk_out.
  - busy = (state==RUN).
  - Latency from en rising to the first clk_out high: 1 clk_in cycle.
- Widths:
  - cnt and active are DIV_W bits.
  - Comparisons are unsigned; cnt+1 cannot overflow because active ≤ 2^DIV_W-1.
- Channels are fully independent; there are no cross-channel interactions.

Decomposition:
- Shared package (clk_div_pkg):
  - Channel state encoding: IDLE=1'b0, RUN=1'b1.
  - Constant DIV_MIN=2.
  - Clamp function used by the write path.
- Sub-module clk_div_chan, one channel: counter, FSM, shadow/pending, negedge register.
- clk_div_prog instantiates NUM_CH copies in a generate loop and slices div_in.

Test Plan:
- Reset, then en[0]=1 with default DIV_INIT=12 -> clk_out[0] is high 6 / low 6 clk_in cycles; tick every 12 cycles; busy[0]=1.
- Write div_in=5 on ch0 while running at 12 -> the current 12-cycle period completes; upd_done pulses at the boundary; then clk_out[0] is high 2.5 / low 2.5 cycles (negedge-extended), with tick every 5 cycles.
- Write 0 on ch1, then en[1]=1 -> divisor clamped to 2; clk_out[1] toggles every clk_in cycle (1 high / 1 low).
- Drop en[0] at cnt=3 with divisor 8 -> clk_out stays high through cnt 0..3, stays low through cnt 4..7, then IDLE with busy=0 and no glitch or truncated pulse.
- div_wr of 7 in the exact boundary cycle of a divisor-4 channel -> the next period is still 4 cycles; the period after is 7; upd_done fires once, at the second boundary.
- Assert rst for 1 cycle mid-period (ch0 at 9, ch1 at 3) -> all outputs go to 0 immediately and asynchronously; after release with en held, both channels restart at DIV_INIT=12 one cycle later.
